// File: rtl/mux_nto1_scan.sv
// -----------------------------------------------------------------------------
// mux_nto1_scan
//   Registered N-to-1 multiplexer with a built-in round-robin channel scanner.
//   One W-bit lane out of CH packed input lanes is captured each enabled clock.
//   The lane is chosen either by the direct select `s` (mode 0) or by an
//   internal scan pointer that walks 0..CH-1 and wraps (mode 1).
//
// Parameters
//   CH    number of input channels (2..256, need not be a power of two)
//   W     width of each channel in bits (1..64)
//   SELW  select/pointer width, max(1, clog2(CH)); derived, not overridable
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset, priority over everything
//   din         packed lanes, channel k at din[k*W +: W]
//   s           direct channel select, used in mode 0
//   mode        0 = direct select, 1 = auto-scan
//   en          sample enable; when low only dout_valid/scan_wrap drop
//   dout        registered selected lane
//   dout_valid  dout was loaded from a legal channel on the last edge
//   ch_id       channel index that produced dout
//   scan_wrap   one-cycle pulse when dout holds channel CH-1 in auto-scan
// -----------------------------------------------------------------------------
module mux_nto1_scan #(
  parameter  int CH   = 8,
  parameter  int W    = 1,
  localparam int SELW = (CH > 2) ? $clog2(CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CH*W-1:0]   din,
  input  logic [SELW-1:0]   s,
  input  logic              mode,
  input  logic              en,
  output logic [W-1:0]      dout,
  output logic              dout_valid,
  output logic [SELW-1:0]   ch_id,
  output logic              scan_wrap
);

  // One extra bit so CH itself is representable when CH is a power of two.
  localparam logic [SELW:0]   LP_CH   = (SELW+1)'(CH);
  localparam logic [SELW-1:0] LP_LAST = SELW'(CH - 1);

  logic [SELW-1:0] r_ptr;
  logic [W-1:0]    r_dout;
  logic            r_valid;
  logic [SELW-1:0] r_ch_id;
  logic            r_wrap;

  logic [SELW-1:0] w_idx;
  logic            w_legal;
  logic [W-1:0]    w_lane;

  // Channel being sampled this cycle. The scan pointer is always < CH, so
  // only a direct select can address a channel that does not exist.
  assign w_idx   = mode ? r_ptr : s;
  assign w_legal = mode | ({1'b0, s} < LP_CH);

  // Lane selection by comparison rather than a variable part-select, so an
  // out-of-range direct select never indexes past the end of din.
  always_comb begin
    // NOTE: default assignment first so every path drives w_lane; without it
    // the partially-assigned variable would infer a latch.
    w_lane = '0;
    for (int k = 0; k < CH; k++) begin
      if (w_idx == SELW'(k)) begin
        w_lane = din[k*W +: W];
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge
    // value of r_ptr; blocking here would let later lines see the new pointer.
    if (rst) begin
      r_ptr   <= '0;
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_ch_id <= '0;
      r_wrap  <= 1'b0;
    end else if (!en) begin
      // Pause: data, channel id and scan position hold.
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_dout  <= w_legal ? w_lane : '0;
      r_ch_id <= w_idx;
      r_valid <= w_legal;
      if (mode) begin
        // Wrap at CH-1, not at the natural 2^SELW rollover.
        r_ptr  <= (r_ptr == LP_LAST) ? '0 : r_ptr + SELW'(1);
        r_wrap <= (r_ptr == LP_LAST);
      end else begin
        // Direct select seeds the scan start; an illegal select restarts at 0.
        r_ptr  <= w_legal ? s : '0;
        r_wrap <= 1'b0;
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign ch_id      = r_ch_id;
  assign scan_wrap  = r_wrap;

endmodule

// File: tb/tb_mux_nto1_scan.sv
// -----------------------------------------------------------------------------
// tb_mux_nto1_scan
//   Two instances of mux_nto1_scan: config 0 (CH=8, W=1) and config 1
//   (CH=5, W=8). Each has its own stimulus. A behavioural model of the
//   channel sampler predicts every output after every clock; directed
//   sequences add literal expectations for the documented scenarios, then a
//   randomized phase exercises both instances together.
// -----------------------------------------------------------------------------
module tb_mux_nto1_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus, indexed by config (0: CH=8 W=1, 1: CH=5 W=8).
  logic       t_rst  [2];
  logic       t_en   [2];
  logic       t_mode [2];
  logic [2:0] t_s    [2];
  logic [7:0] lane   [2][8];

  logic [7:0]  din8;
  logic [39:0] din5;

  always_comb begin
    for (int k = 0; k < 8; k++) din8[k] = lane[0][k][0];
    for (int k = 0; k < 5; k++) din5[k*8 +: 8] = lane[1][k];
  end

  logic       dout8, dv8, wr8;
  logic [2:0] id8;
  logic [7:0] dout5;
  logic       dv5, wr5;
  logic [2:0] id5;

  mux_nto1_scan #(.CH(8), .W(1)) u_dut8 (
    .clk(clk), .rst(t_rst[0]), .din(din8), .s(t_s[0]), .mode(t_mode[0]),
    .en(t_en[0]), .dout(dout8), .dout_valid(dv8), .ch_id(id8), .scan_wrap(wr8)
  );

  mux_nto1_scan #(.CH(5), .W(8)) u_dut5 (
    .clk(clk), .rst(t_rst[1]), .din(din5), .s(t_s[1]), .mode(t_mode[1]),
    .en(t_en[1]), .dout(dout5), .dout_valid(dv5), .ch_id(id5), .scan_wrap(wr5)
  );

  // Observed outputs gathered per config.
  logic [7:0] g_dout [2];
  logic [2:0] g_id   [2];
  logic       g_v    [2];
  logic       g_w    [2];
  assign g_dout[0] = {7'b0, dout8};
  assign g_dout[1] = dout5;
  assign g_id[0]   = id8;
  assign g_id[1]   = id5;
  assign g_v[0]    = dv8;
  assign g_v[1]    = dv5;
  assign g_w[0]    = wr8;
  assign g_w[1]    = wr5;

  // Reference model state.
  int         m_ptr  [2];
  logic [7:0] m_dout [2];
  int         m_id   [2];
  logic       m_v    [2];
  logic       m_w    [2];

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ch_of(input int c);
    return (c == 0) ? 8 : 5;
  endfunction

  // What one enabled/disabled clock edge does to a channel sampler.
  task automatic model_clk(input int c);
    int n;
    int sel;
    n   = ch_of(c);
    sel = int'(t_s[c]);
    if (t_rst[c]) begin
      m_ptr[c] = 0; m_dout[c] = 0; m_id[c] = 0; m_v[c] = 0; m_w[c] = 0;
    end else if (!t_en[c]) begin
      m_v[c] = 0; m_w[c] = 0;
    end else if (!t_mode[c]) begin
      m_id[c] = sel;
      m_w[c]  = 0;
      if (sel < n) begin
        m_dout[c] = lane[c][sel]; m_v[c] = 1; m_ptr[c] = sel;
      end else begin
        m_dout[c] = 0; m_v[c] = 0; m_ptr[c] = 0;
      end
    end else begin
      m_dout[c] = lane[c][m_ptr[c]];
      m_id[c]   = m_ptr[c];
      m_v[c]    = 1;
      m_w[c]    = (m_ptr[c] == n - 1);
      m_ptr[c]  = (m_ptr[c] + 1) % n;
    end
  endtask

  // Advance one clock and compare both instances with the model.
  task automatic step();
    model_clk(0);
    model_clk(1);
    @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      check($sformatf("c%0d dout", c),  32'(g_dout[c]), 32'(m_dout[c]));
      check($sformatf("c%0d id", c),    32'(g_id[c]),   32'(m_id[c]));
      check($sformatf("c%0d valid", c), 32'(g_v[c]),    32'(m_v[c]));
      check($sformatf("c%0d wrap", c),  32'(g_w[c]),    32'(m_w[c]));
    end
  endtask

  int exp_id [11] = '{6, 6, 7, 0, 1, 2, 3, 4, 5, 6, 7};
  int exp_d  [11] = '{0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0};
  int dir_s  [4]  = '{4, 1, 3, 5};
  int dir_d  [4]  = '{1, 0, 1, 0};

  initial begin
    logic [7:0] pat;
    for (int c = 0; c < 2; c++) begin
      t_rst[c] = 1'b1; t_en[c] = 1'b0; t_mode[c] = 1'b0; t_s[c] = '0;
      m_ptr[c] = 0; m_dout[c] = 0; m_id[c] = 0; m_v[c] = 0; m_w[c] = 0;
    end
    pat = 8'b0001_1001;
    for (int k = 0; k < 8; k++) lane[0][k] = {7'b0, pat[k]};
    for (int k = 0; k < 8; k++) lane[1][k] = (k < 5) ? 8'((k + 1) * 8'h11) : 8'h00;

    // Reset held two cycles, then one idle cycle after release.
    step();
    step();
    check("rst dout", 32'(dout8), 0);
    check("rst valid", 32'(dv8), 0);
    t_rst[0] = 1'b0;
    t_rst[1] = 1'b0;
    step();
    check("post-rst id", 32'(id8), 0);
    check("post-rst wrap", 32'(wr8), 0);

    // Direct select on the 8-channel instance.
    t_en[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      t_s[0] = 3'(dir_s[i]);
      step();
      check($sformatf("direct dout s=%0d", dir_s[i]), 32'(dout8), 32'(dir_d[i]));
      check($sformatf("direct id s=%0d", dir_s[i]), 32'(id8), 32'(dir_s[i]));
      check("direct valid", 32'(dv8), 1);
    end

    // Seed at 6, then auto-scan ten cycles through the wrap.
    for (int i = 0; i < 11; i++) begin
      t_s[0]    = (i == 0) ? 3'd6 : 3'($urandom_range(0, 7));
      t_mode[0] = (i != 0);
      step();
      check($sformatf("scan id #%0d", i), 32'(id8), 32'(exp_id[i]));
      check($sformatf("scan dout #%0d", i), 32'(dout8), 32'(exp_d[i]));
      check($sformatf("scan wrap #%0d", i), 32'(wr8), 32'(exp_id[i] == 7 && i != 0));
    end

    // Two more samples to park the pointer at 2, then a three-cycle gap.
    step();
    step();
    t_en[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("gap valid", 32'(dv8), 0);
      check("gap id hold", 32'(id8), 1);
    end
    t_en[0] = 1'b1;
    step();
    check("resume id", 32'(id8), 2);
    check("resume valid", 32'(dv8), 1);

    // Reach pointer 5, then reset mid-scan with en and mode still high.
    step();
    step();
    t_rst[0] = 1'b1;
    step();
    check("midrst id", 32'(id8), 0);
    check("midrst valid", 32'(dv8), 0);
    t_rst[0] = 1'b0;
    step();
    check("after-rst first id", 32'(id8), 0);
    check("after-rst first valid", 32'(dv8), 1);

    // Non-power-of-two instance: illegal direct select, then scan.
    t_en[1]   = 1'b1;
    t_mode[1] = 1'b0;
    t_s[1]    = 3'd6;
    step();
    check("np2 illegal dout", 32'(dout5), 0);
    check("np2 illegal valid", 32'(dv5), 0);
    check("np2 illegal id", 32'(id5), 6);
    t_mode[1] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      check($sformatf("np2 id #%0d", i), 32'(id5), 32'(i % 5));
      check($sformatf("np2 dout #%0d", i), 32'(dout5), 32'(((i % 5) + 1) * 'h11));
      check($sformatf("np2 wrap #%0d", i), 32'(wr5), 32'(i % 5 == 4));
    end

    // Randomized phase on both instances.
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < 2; c++) begin
        t_rst[c]  = ($urandom_range(0, 39) == 0);
        t_en[c]   = ($urandom_range(0, 3) != 0);
        t_mode[c] = ($urandom_range(0, 2) != 0);
        t_s[c]    = 3'($urandom_range(0, 7));
        for (int k = 0; k < 8; k++)
          lane[c][k] = (c == 0) ? 8'($urandom_range(0, 1)) : 8'($urandom_range(0, 255));
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
